// File: rtl/rr_arbiter_4_dec_pkg.sv
// Shared constants, state encoding and round-robin selection helper for the
// four-requester arbiter.
package rr_arbiter_4_dec_pkg;

  localparam int N_REQ            = 4;
  localparam int IDX_W            = 2;
  localparam int MAX_HOLD_DEFAULT = 15;
  localparam int HOLD_W           = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // First set request at or after ptr, scanning upward and wrapping modulo 4.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] sel;
    logic             found;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_dec_grant_decoder.sv
// Active-low 2-to-4 decoder: D[{B,A}] is pulled low while enable_n is low.
module grant_decoder_2x4 (
  input  logic       A,
  input  logic       B,
  input  logic       enable_n,
  output logic [0:3] D
);

  always_comb begin
    D = 4'b1111;
    if (!enable_n) begin
      D[{B, A}] = 1'b0;
    end
  end

endmodule

// File: rtl/rr_arbiter_4_dec.sv
// Four-way round-robin arbiter with hold-time limit; the active-low one-hot
// grant is decoded from the registered owner index.
module rr_arbiter_4_dec
  import rr_arbiter_4_dec_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT  // legal range 2..255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [0:3]       gnt_n,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    owner, owner_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic                valid_nxt;
  logic                timeout_nxt;
  logic                expired;
  logic                released;
  logic                grant_en_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_cnt_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;
    valid_nxt    = 1'b0;
    timeout_nxt  = 1'b0;
    expired      = (hold_cnt == HOLD_LAST);
    released     = done || !req[owner];
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt    = GRANT;
          owner_nxt    = rr_pick(req, ptr);
          hold_cnt_nxt = '0;
          valid_nxt    = 1'b1;
        end
      end
      GRANT: begin
        hold_cnt_nxt = expired ? hold_cnt : hold_cnt + 1'b1;
        if (released || expired) begin
          state_nxt = RELEASE;
          // A voluntary release wins over a coincident expiry.
          timeout_nxt = expired && !released;
        end else begin
          valid_nxt = 1'b1;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        ptr_nxt   = owner + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_idx    = owner;
  assign grant_en_n = ~gnt_valid;

  grant_decoder_2x4 u_grant_decoder (
    .A        (gnt_idx[0]),
    .B        (gnt_idx[1]),
    .enable_n (grant_en_n),
    .D        (gnt_n)
  );

endmodule

// File: tb/tb_rr_arbiter_4_dec.sv
// Directed bench for rr_arbiter_4_dec with MAX_HOLD at its default of 15.
module tb_rr_arbiter_4_dec;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [0:3] gnt_n;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;
  int hold_len;

  logic [3:0] dec_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [1:0] rot_tab [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  rr_arbiter_4_dec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Structural grant checks applied after every clock edge.
  task automatic inv();
    int         zeros;
    logic [0:3] exp_d;
    zeros = 0;
    for (int i = 0; i < 4; i++) if (gnt_n[i] === 1'b0) zeros++;
    chk("onehot", 8'(zeros <= 1), 8'd1);
    if (gnt_valid === 1'b1) begin
      exp_d = 4'b1111;
      exp_d[gnt_idx] = 1'b0;
      chk("dec_match", 8'(gnt_n), 8'(exp_d));
    end else begin
      chk("dec_off", 8'(gnt_n), 8'h0F);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    inv();
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] idx, input logic [3:0] gn);
    chk({tag, "_valid"}, 8'(gnt_valid), 8'd1);
    chk({tag, "_idx"}, 8'(gnt_idx), 8'(idx));
    chk({tag, "_gnt_n"}, 8'(gnt_n), 8'(gn));
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_valid"}, 8'(gnt_valid), 8'd0);
    chk({tag, "_gnt_n"}, 8'(gnt_n), 8'h0F);
  endtask

  // From a freshly granted cycle: done pulses on the third grant edge, then RELEASE and IDLE.
  task automatic release_done(input string tag);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_off({tag, "_rel"});
    chk({tag, "_rel_to"}, 8'(timeout), 8'd0);
    tick();
    chk_off({tag, "_idle"});
  endtask

  // Called at posedge+1: asserts reset mid-cycle, checks, releases after one edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk_off({tag, "_rst"});
    chk({tag, "_rst_idx"}, 8'(gnt_idx), 8'd0);
    chk({tag, "_rst_to"}, 8'(timeout), 8'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    // Power-on reset state
    tick();
    chk_off("por");
    chk("por_idx", 8'(gnt_idx), 8'd0);
    chk("por_to", 8'(timeout), 8'd0);
    rst_n = 1'b1;
    tick();
    chk_off("idle_noreq");

    // req=0101 with done pulses: owners 0,2,0,2
    req = 4'b0101;
    tick();
    chk_grant("a0", 2'd0, 4'b0111);
    release_done("a0");
    tick();
    chk_grant("a1", 2'd2, 4'b1101);
    release_done("a1");
    tick();
    chk_grant("a2", 2'd0, 4'b0111);
    release_done("a2");
    tick();
    chk_grant("a3", 2'd2, 4'b1101);
    req = 4'b0000;
    tick();
    chk_off("a_drop");
    chk("a_drop_to", 8'(timeout), 8'd0);
    tick();

    // req=1111, done never asserted: 15-cycle grants, timeout each, rotating owners
    do_reset("b");
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_grant("b_own", rot_tab[k], dec_tab[rot_tab[k]]);
      hold_len = 1;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (gnt_valid !== 1'b1) break;
        hold_len++;
      end
      chk("b_len", 8'(hold_len), 8'd15);
      chk("b_to_pulse", 8'(timeout), 8'd1);
      tick();
      chk("b_to_clear", 8'(timeout), 8'd0);
    end

    // done coincident with expiry: normal release, no timeout
    tick();
    chk_grant("c_own", 2'd1, 4'b1011);
    for (int c = 0; c < 14; c++) tick();
    chk("c_still", 8'(gnt_valid), 8'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_off("c_rel");
    chk("c_to", 8'(timeout), 8'd0);
    req = 4'b0000;
    tick();

    // Pointer wrap with req=1001, non-owner changes ignored, done ignored in IDLE
    do_reset("d");
    req = 4'b1001;
    tick();
    chk_grant("d0", 2'd0, 4'b0111);
    release_done("d0");
    tick();
    chk_grant("d1", 2'd3, 4'b1110);
    req = 4'b1011;
    tick();
    chk_grant("d1_hold", 2'd3, 4'b1110);
    req = 4'b1001;
    release_done("d1");
    tick();
    chk_grant("d2", 2'd0, 4'b0111);
    req = 4'b1000;
    tick();
    chk_off("d2_drop");
    chk("d2_drop_to", 8'(timeout), 8'd0);
    done = 1'b1;
    tick();
    chk_off("d_idle_done");
    tick();
    chk_grant("d3", 2'd3, 4'b1110);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    tick();

    // Asynchronous reset mid-GRANT, then fresh arbitration
    rst_n = 1'b1;
    do_reset("f_pre");
    req = 4'b0010;
    tick();
    chk_grant("f0", 2'd1, 4'b1011);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_off("f_async");
    chk("f_async_idx", 8'(gnt_idx), 8'd0);
    req = 4'b0100;
    #3;
    rst_n = 1'b1;
    tick();
    chk_grant("f1", 2'd2, 4'b1101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
